// File: rtl/seq_divider_if.sv
// Handshake and adder-side bus of the sequential divider.
// The slave side is the divider; the master side is the control unit plus the shared add/sub unit.
interface seq_divider_if #(
    parameter int WIDTH = 32
);
    logic             start;
    logic [WIDTH-1:0] dividend;
    logic [WIDTH-1:0] divisor;
    logic [WIDTH-1:0] add_x;
    logic [WIDTH-1:0] add_y;
    logic             add_sub;
    logic [WIDTH-1:0] add_s;
    logic             busy;
    logic             done;
    logic             div_zero;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;

    modport slave (
        input  start, dividend, divisor, add_s,
        output add_x, add_y, add_sub, busy, done, div_zero, hi, lo
    );

    modport master (
        output start, dividend, divisor, add_s,
        input  add_x, add_y, add_sub, busy, done, div_zero, hi, lo
    );
endinterface

// File: rtl/seq_divider.sv
// Signed non-restoring divider: one add/sub per clock on the shared external adder,
// quotient to lo, remainder to hi, with start/busy/done handshake.
module seq_divider #(
    parameter int WIDTH = 32,
    parameter int ITER  = 32
) (
    input  logic           clock,
    input  logic           clear,
    seq_divider_if.slave   bus
);
    localparam int CW = $clog2(ITER);
    localparam logic [WIDTH-1:0] ZERO = {WIDTH{1'b0}};
    localparam logic [WIDTH-1:0] ONE  = {{(WIDTH-1){1'b0}}, 1'b1};

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_ITER = 3'd1,
        S_CORR = 3'd2,
        S_FIX  = 3'd3,
        S_DONE = 3'd4
    } state_e;

    function automatic logic [WIDTH-1:0] negate_f(input logic [WIDTH-1:0] v);
        return ~v + ONE;
    endfunction

    // The most negative value maps to itself and is then read as unsigned.
    function automatic logic [WIDTH-1:0] abs_f(input logic [WIDTH-1:0] v);
        return v[WIDTH-1] ? negate_f(v) : v;
    endfunction

    state_e           state_q, state_d;
    logic             ae_q, ae_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] q_q, q_d;
    logic [WIDTH-1:0] d_q, d_d;
    logic [CW-1:0]    count_q, count_d;
    logic             qneg_q, qneg_d;
    logic             rneg_q, rneg_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             div_zero_q, div_zero_d;
    logic [WIDTH-1:0] hi_q, hi_d;
    logic [WIDTH-1:0] lo_q, lo_d;

    logic [WIDTH-1:0] add_x_s;
    logic [WIDTH-1:0] add_y_s;
    logic             add_sub_s;
    logic [WIDTH-1:0] yy_s;
    logic             cout_s;
    logic             ae_new_s;

    // Adder operand drive, decoded purely from registered state.
    always_comb begin
        add_x_s   = ZERO;
        add_y_s   = ZERO;
        add_sub_s = 1'b0;
        case (state_q)
            S_ITER: begin
                add_x_s   = {a_q[WIDTH-2:0], q_q[WIDTH-1]};
                add_y_s   = d_q;
                add_sub_s = ~ae_q;
            end
            S_CORR: begin
                add_x_s   = a_q;
                add_y_s   = d_q;
                add_sub_s = 1'b0;
            end
            default: begin
                add_x_s   = ZERO;
                add_y_s   = ZERO;
                add_sub_s = 1'b0;
            end
        endcase
    end

    // Recover the 33rd bit of the partial remainder from the adder's top-bit carry.
    always_comb begin
        yy_s     = add_sub_s ? ~add_y_s : add_y_s;
        cout_s   = (add_x_s[WIDTH-1] & yy_s[WIDTH-1]) |
                   ((add_x_s[WIDTH-1] ^ yy_s[WIDTH-1]) & ~bus.add_s[WIDTH-1]);
        ae_new_s = a_q[WIDTH-1] ^ add_sub_s ^ cout_s;
    end

    // Next-state and datapath update.
    always_comb begin
        state_d    = state_q;
        ae_d       = ae_q;
        a_d        = a_q;
        q_d        = q_q;
        d_d        = d_q;
        count_d    = count_q;
        qneg_d     = qneg_q;
        rneg_d     = rneg_q;
        busy_d     = busy_q;
        done_d     = 1'b0;
        div_zero_d = div_zero_q;
        hi_d       = hi_q;
        lo_d       = lo_q;
        case (state_q)
            S_IDLE: begin
                if (bus.start && (bus.divisor == ZERO)) begin
                    lo_d       = {WIDTH{1'b1}};
                    hi_d       = bus.dividend;
                    div_zero_d = 1'b1;
                    done_d     = 1'b1;
                    busy_d     = 1'b0;
                    state_d    = S_DONE;
                end else if (bus.start) begin
                    ae_d       = 1'b0;
                    a_d        = ZERO;
                    q_d        = abs_f(bus.dividend);
                    d_d        = abs_f(bus.divisor);
                    count_d    = {CW{1'b0}};
                    qneg_d     = bus.dividend[WIDTH-1] ^ bus.divisor[WIDTH-1];
                    rneg_d     = bus.dividend[WIDTH-1];
                    div_zero_d = 1'b0;
                    busy_d     = 1'b1;
                    state_d    = S_ITER;
                end else begin
                    state_d    = S_IDLE;
                end
            end
            S_ITER: begin
                a_d     = bus.add_s;
                ae_d    = ae_new_s;
                q_d     = {q_q[WIDTH-2:0], ~ae_new_s};
                count_d = count_q + {{(CW-1){1'b0}}, 1'b1};
                if (count_q == CW'(ITER - 1)) begin
                    state_d = S_CORR;
                end else begin
                    state_d = S_ITER;
                end
            end
            S_CORR: begin
                if (ae_q) begin
                    a_d = bus.add_s;
                end else begin
                    a_d = a_q;
                end
                state_d = S_FIX;
            end
            S_FIX: begin
                lo_d    = qneg_q ? negate_f(q_q) : q_q;
                hi_d    = rneg_q ? negate_f(a_q) : a_q;
                busy_d  = 1'b0;
                done_d  = 1'b1;
                state_d = S_IDLE;
            end
            S_DONE: begin
                busy_d  = 1'b0;
                state_d = S_IDLE;
            end
            default: begin
                busy_d  = 1'b0;
                state_d = S_IDLE;
            end
        endcase
    end

    // State and datapath registers.
    always_ff @(posedge clock or negedge clear) begin
        if (!clear) begin
            state_q    <= S_IDLE;
            ae_q       <= 1'b0;
            a_q        <= ZERO;
            q_q        <= ZERO;
            d_q        <= ZERO;
            count_q    <= {CW{1'b0}};
            qneg_q     <= 1'b0;
            rneg_q     <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            div_zero_q <= 1'b0;
            hi_q       <= ZERO;
            lo_q       <= ZERO;
        end else begin
            state_q    <= state_d;
            ae_q       <= ae_d;
            a_q        <= a_d;
            q_q        <= q_d;
            d_q        <= d_d;
            count_q    <= count_d;
            qneg_q     <= qneg_d;
            rneg_q     <= rneg_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            div_zero_q <= div_zero_d;
            hi_q       <= hi_d;
            lo_q       <= lo_d;
        end
    end

    assign bus.add_x    = add_x_s;
    assign bus.add_y    = add_y_s;
    assign bus.add_sub  = add_sub_s;
    assign bus.busy     = busy_q;
    assign bus.done     = done_q;
    assign bus.div_zero = div_zero_q;
    assign bus.hi       = hi_q;
    assign bus.lo       = lo_q;
endmodule

// File: tb/tb_seq_divider.sv
// Self-checking bench for seq_divider: directed vector table, hand-written corner
// sequences and a random scoreboard, with a behavioural model of the shared adder.
module tb_seq_divider;
    logic clock;
    logic clear;
    int   n_pass;
    int   n_total;

    seq_divider_if #(.WIDTH(32)) bus ();

    seq_divider #(.WIDTH(32), .ITER(32)) dut (
        .clock (clock),
        .clear (clear),
        .bus   (bus)
    );

    assign bus.add_s = bus.add_sub ? (bus.add_x - bus.add_y) : (bus.add_x + bus.add_y);

    initial clock = 1'b0;
    always #5 clock = ~clock;

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] exp_lo;
        logic [31:0] exp_hi;
        logic        exp_dz;
        int          exp_edge;
    } vec_t;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    function automatic void ref_div(input logic [31:0] a, input logic [31:0] b,
                                    output logic [31:0] q, output logic [31:0] r,
                                    output logic dz);
        dz = 1'b0;
        if (b == 32'd0) begin
            q  = 32'hFFFFFFFF;
            r  = a;
            dz = 1'b1;
        end else if (a == 32'h80000000 && b == 32'hFFFFFFFF) begin
            q = 32'h80000000;
            r = 32'd0;
        end else begin
            q = $signed(a) / $signed(b);
            r = $signed(a) % $signed(b);
        end
    endfunction

    // Edge numbering: the start edge is edge 0; an output registered on edge k is
    // seen by edge k+1, so a sample taken #1 after edge s reports "edge s+1".
    task automatic run_div(input logic [31:0] a, input logic [31:0] b, input bit trace,
                           input int poke_at, output int done_edge,
                           output logic [31:0] q, output logic [31:0] r,
                           output logic dz, output int busy_cnt);
        longint p;
        longint dd;
        longint p2;
        logic [31:0] n;
        logic [31:0] bb;
        bb           = b;
        n            = a[31] ? (~a + 32'd1) : a;
        dd           = bb[31] ? longint'(~bb + 32'd1) : longint'(bb);
        p            = 64'sd0;
        done_edge    = -1;
        busy_cnt     = 0;
        q            = 32'hx;
        r            = 32'hx;
        dz           = 1'bx;
        bus.start    = 1'b1;
        bus.dividend = a;
        bus.divisor  = b;
        @(posedge clock);
        #1;
        bus.start    = 1'b0;
        bus.dividend = $urandom;
        bus.divisor  = $urandom;
        for (int s = 0; s < 60; s++) begin
            if (s > 0) begin
                @(posedge clock);
                #1;
                if (s == poke_at) bus.start = 1'b0;
            end
            if (bus.done) begin
                done_edge = s + 1;
                q  = bus.lo;
                r  = bus.hi;
                dz = bus.div_zero;
                break;
            end
            if (bus.busy) busy_cnt++;
            if (trace && s < 32) begin
                p2 = 2 * p + longint'(n[31 - s]);
                check("iter_add_sub", {31'd0, bus.add_sub}, {31'd0, (p >= 0)});
                check("iter_add_x", bus.add_x, p2[31:0]);
                p = (p >= 0) ? (p2 - dd) : (p2 + dd);
            end
            if (s + 1 == poke_at) begin
                bus.start    = 1'b1;
                bus.dividend = 32'd1000;
                bus.divisor  = 32'd3;
            end
        end
    endtask

    vec_t        vecs[8];
    int          de;
    int          bc;
    int          seen_done;
    logic [31:0] rq;
    logic [31:0] rr;
    logic        rdz;
    logic [31:0] eq;
    logic [31:0] er;
    logic        edz;
    logic [31:0] ra;
    logic [31:0] rb;

    initial begin
        n_pass = 0;
        n_total = 0;
        vecs[0] = '{32'd100,        32'd7,          32'd14,         32'd2,          1'b0, 35};
        vecs[1] = '{-32'sd100,      32'd7,          32'hFFFFFFF2,   32'hFFFFFFFE,   1'b0, 35};
        vecs[2] = '{32'd100,        -32'sd7,        32'hFFFFFFF2,   32'd2,          1'b0, 35};
        vecs[3] = '{32'd5,          32'd0,          32'hFFFFFFFF,   32'd5,          1'b1, 1};
        vecs[4] = '{32'd6,          32'd3,          32'd2,          32'd0,          1'b0, 35};
        vecs[5] = '{32'h80000000,   32'hFFFFFFFF,   32'h80000000,   32'd0,          1'b0, 35};
        vecs[6] = '{32'd7,          32'h80000000,   32'd0,          32'd7,          1'b0, 35};
        vecs[7] = '{32'h7FFFFFFF,   32'd1,          32'h7FFFFFFF,   32'd0,          1'b0, 35};

        clear        = 1'b0;
        bus.start    = 1'b0;
        bus.dividend = 32'd0;
        bus.divisor  = 32'd0;
        repeat (3) @(posedge clock);
        #1;
        check("rst_busy", {31'd0, bus.busy}, 32'd0);
        check("rst_done", {31'd0, bus.done}, 32'd0);
        check("rst_div_zero", {31'd0, bus.div_zero}, 32'd0);
        check("rst_hi", bus.hi, 32'd0);
        check("rst_lo", bus.lo, 32'd0);
        check("rst_add_x", bus.add_x, 32'd0);
        clear = 1'b1;
        @(posedge clock);
        #1;

        for (int i = 0; i < 8; i++) begin
            run_div(vecs[i].a, vecs[i].b, (i == 0), -1, de, rq, rr, rdz, bc);
            check("done_edge", de, vecs[i].exp_edge);
            check("lo", rq, vecs[i].exp_lo);
            check("hi", rr, vecs[i].exp_hi);
            check("div_zero", {31'd0, rdz}, {31'd0, vecs[i].exp_dz});
            check("busy_at_done", {31'd0, bus.busy}, 32'd0);
            if (i == 0) check("busy_cycles", bc, 34);
            @(posedge clock);
            #1;
            check("done_pulse_end", {31'd0, bus.done}, 32'd0);
            check("idle_add_x", bus.add_x, 32'd0);
            check("idle_add_y", bus.add_y, 32'd0);
            check("idle_add_sub", {31'd0, bus.add_sub}, 32'd0);
            check("div_zero_held", {31'd0, bus.div_zero}, {31'd0, vecs[i].exp_dz});
            check("lo_held", bus.lo, vecs[i].exp_lo);
        end

        // A second start at edge 10 must be ignored.
        run_div(32'd100, 32'd7, 1'b0, 10, de, rq, rr, rdz, bc);
        check("restart_edge", de, 35);
        check("restart_lo", rq, 32'd14);
        check("restart_hi", rr, 32'd2);
        @(posedge clock);
        #1;

        // Asynchronous clear in the middle of an operation aborts it silently.
        bus.start    = 1'b1;
        bus.dividend = 32'd100;
        bus.divisor  = 32'd7;
        @(posedge clock);
        #1;
        bus.start = 1'b0;
        repeat (19) @(posedge clock);
        #1;
        clear = 1'b0;
        #1;
        check("clr_busy", {31'd0, bus.busy}, 32'd0);
        check("clr_hi", bus.hi, 32'd0);
        check("clr_lo", bus.lo, 32'd0);
        check("clr_add_x", bus.add_x, 32'd0);
        @(negedge clock);
        clear = 1'b1;
        seen_done = 0;
        repeat (40) begin
            @(posedge clock);
            #1;
            if (bus.done) seen_done++;
        end
        check("clr_no_done", seen_done, 0);

        for (int k = 0; k < 1000; k++) begin
            ra = $urandom;
            rb = $urandom;
            if (k % 4 == 1) rb = $urandom_range(0, 16) - 32'd8;
            if (k % 9 == 2) ra = $urandom_range(0, 100);
            if (k == 3) begin
                ra = 32'h80000000;
                rb = 32'd3;
            end
            ref_div(ra, rb, eq, er, edz);
            run_div(ra, rb, 1'b0, -1, de, rq, rr, rdz, bc);
            check("rnd_lo", rq, eq);
            check("rnd_hi", rr, er);
            check("rnd_div_zero", {31'd0, rdz}, {31'd0, edz});
            @(posedge clock);
            #1;
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
